serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: captures A/B, ripples one borrow bit per clock LSB first,
// and presents D = A-B mod 2^WIDTH with the final borrow on BOUT under a valid/ready handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic              br_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  d_q;
    logic              bout_q;

    logic              a0;
    logic              b0;
    logic              d_bit;
    logic              br_d;
    logic [WIDTH-1:0]  diff_d;
    logic              last_bit;

    // One full-subtractor slice, fed from the operand LSBs
    always_comb begin
        a0       = a_q[0];
        b0       = b_q[0];
        d_bit    = a0 ^ b0 ^ br_q;
        br_d     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    diff_q <= diff_d;
                    br_q   <= br_d;
                    if (last_bit) begin
                        // Publish straight from the final slice so DONE sees the full result
                        d_q     <= diff_d;
                        bout_q  <= br_d;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (OUT_READY) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign IN_READY  = (state_q == StIdle);
    assign OUT_VALID = (state_q == StDone);
    assign D         = d_q;
    assign BOUT      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         bout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(
        .WIDTH(W)
    ) u_dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .A        (a),
        .B        (b),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .D        (d),
        .BOUT     (bout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one pair at a negedge; returns just after the accepting edge with inputs scrambled
    task automatic start_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v);
        @(negedge clk);
        check("in_ready before accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = a_v;
        b        = b_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~a_v;
        b        = a_v ^ 8'h3c;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic retire(input logic [W-1:0] exp_d, input logic exp_bout);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after retire", 32'(out_valid), 32'd0);
        check("in_ready after retire", 32'(in_ready), 32'd1);
        check("d retained in idle", 32'(d), 32'(exp_d));
        check("bout retained in idle", 32'(bout), 32'(exp_bout));
    endtask

    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [W-1:0] exp_d, input logic exp_bout);
        int lat;
        start_op(a_v, b_v);
        wait_done(lat);
        check("latency", 32'(lat), 32'd8);
        check("d", 32'(d), 32'(exp_d));
        check("bout", 32'(bout), 32'(exp_bout));
        check("in_ready low in done", 32'(in_ready), 32'd0);
        retire(exp_d, exp_bout);
    endtask

    logic [W:0] exp_q[$];
    logic [W:0] e;

    initial begin
        int lat;
        int bad;
        int last_acc;
        int n_seen;

        // Reset values, sampled while reset is held
        #2;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst d", 32'(d), 32'd0);
        check("rst bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h5a, 8'h3c, 8'h1e, 1'b0);
        run_op(8'h00, 8'h01, 8'hff, 1'b1);
        run_op(8'hff, 8'h00, 8'hff, 1'b0);
        run_op(8'ha5, 8'ha5, 8'h00, 1'b0);

        // Backpressure: result must sit untouched while the consumer stalls
        start_op(8'h10, 8'h20);
        wait_done(lat);
        check("hold latency", 32'(lat), 32'd8);
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 8'(i * 7);
            b = 8'(i * 13 + 1);
            @(posedge clk);
            #1;
            if (!out_valid || d !== 8'hf0 || bout !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("hold stable cycles bad", 32'(bad), 32'd0);
        check("hold d", 32'(d), 32'hf0);
        check("hold bout", 32'(bout), 32'd1);
        retire(8'hf0, 1'b1);

        // Asynchronous reset in the middle of BUSY
        start_op(8'h77, 8'h11);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midbusy rst in_ready", 32'(in_ready), 32'd1);
        check("midbusy rst out_valid", 32'(out_valid), 32'd0);
        check("midbusy rst d", 32'(d), 32'd0);
        check("midbusy rst bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 8'h03;
        b        = 8'h01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'hcc;
        b        = 8'hee;
        check("accept on first edge after rst", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("post-rst latency", 32'(lat), 32'd8);
        check("post-rst d", 32'(d), 32'h02);
        check("post-rst bout", 32'(bout), 32'd0);
        retire(8'h02, 1'b0);

        // Streaming: IN_VALID and OUT_READY held high, operands changing every cycle
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_acc  = -1;
        n_seen    = 0;
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("stream d", 32'(d), 32'(e[W-1:0]));
                    check("stream bout", 32'(bout), 32'(e[W]));
                    n_seen++;
                end else begin
                    check("stream unexpected result", 32'd1, 32'd0);
                end
            end
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (in_ready) begin
                exp_q.push_back({1'b0, a} - {1'b0, b});
                if (last_acc >= 0) check("stream spacing", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
            end
        end
        in_valid  = 1'b0;
        check("stream results seen", 32'(n_seen >= 4), 32'd1);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
